// File: rtl/div_result_fifo_if.sv
// Handshake bundle between the divider issuer/consumer side and div_result_fifo.
// slave: the FIFO itself; master: the environment driving Start_req/Done/Out_ready.
interface div_result_fifo_if #(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned DEPTH   = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic               Start_req;
  logic               Start_ok;
  logic               Start;
  logic               Done;
  logic [tamanyo-1:0] Coc;
  logic [tamanyo-1:0] Res;
  logic               Out_valid;
  logic               Out_ready;
  logic [tamanyo-1:0] Out_coc;
  logic [tamanyo-1:0] Out_res;
  logic [LVL_W-1:0]   Level;
  logic               Ovf;

  modport master (
    output Start_req, Done, Coc, Res, Out_ready,
    input  Start_ok, Start, Out_valid, Out_coc, Out_res, Level, Ovf
  );

  modport slave (
    input  Start_req, Done, Coc, Res, Out_ready,
    output Start_ok, Start, Out_valid, Out_coc, Out_res, Level, Ovf
  );
endinterface

// File: rtl/div_result_fifo.sv
// Credit-gated result FIFO behind the non-stallable pipelined signed divider.
// Optional macro DIV_FIFO_OVF_DET_EN enables the sticky Ovf drop detector.
module div_result_fifo #(
  parameter int unsigned tamanyo = 32,
  parameter int unsigned DEPTH   = 8
) (
  input logic              CLK,
  input logic              RSTa,
  div_result_fifo_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * tamanyo;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] level;
  logic [CNT_W-1:0] reservas;
  logic [CNT_W-1:0] level_nxt;
  logic [CNT_W-1:0] reservas_nxt;
  logic             start_ok_q;
  logic             out_valid_q;
  logic             issue;
  logic             pop;
  logic             wr_en;
  logic [ENT_W-1:0] head;

  // Handshake decode and counter updates; gating uses registered state only.
  always_comb begin
    issue        = bus.Start_req & start_ok_q;
    pop          = out_valid_q & bus.Out_ready;
    wr_en        = bus.Done & (level < DEPTH_C) & (reservas > level);
    reservas_nxt = reservas;
    level_nxt    = level;
    if (issue && !pop) begin
      reservas_nxt = reservas + CNT_W'(1);
    end else if (pop && !issue) begin
      reservas_nxt = reservas - CNT_W'(1);
    end
    if (wr_en && !pop) begin
      level_nxt = level + CNT_W'(1);
    end else if (pop && !wr_en) begin
      level_nxt = level - CNT_W'(1);
    end
  end

  // Control state; Start_ok and Out_valid are precomputed from next-state counters.
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      reservas    <= '0;
      start_ok_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level       <= level_nxt;
      reservas    <= reservas_nxt;
      start_ok_q  <= (reservas_nxt < DEPTH_C);
      out_valid_q <= (level_nxt != '0);
    end
  end

  // Storage is not reset; Out_valid masks stale contents.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= {bus.Coc, bus.Res};
    end
  end

  assign head          = out_valid_q ? mem[rd_ptr] : '0;
  assign bus.Out_coc   = head[ENT_W-1:tamanyo];
  assign bus.Out_res   = head[tamanyo-1:0];
  assign bus.Out_valid = out_valid_q;
  assign bus.Start_ok  = start_ok_q;
  assign bus.Start     = issue;
  assign bus.Level     = level;

`ifdef DIV_FIFO_OVF_DET_EN
  logic ovf_q;

  // Sticky flag for any Done that could not be stored.
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      ovf_q <= 1'b0;
    end else if (bus.Done && !wr_en) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.Ovf = ovf_q;
`else
  assign bus.Ovf = 1'b0;
`endif

endmodule
